// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch prediction unit.
//  br_funct3_e     : RV32I conditional-branch funct3 encodings
//  bht_state_e     : 2-bit bimodal counter states
//  BHT_RESET_STATE : value every BHT entry takes on reset
//  funct3_legal()  : 1 when funct3 names one of the six conditional branches
//  branch_cond()   : raw branch condition from the ALU flags
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  localparam bht_state_e BHT_RESET_STATE = WNT;

  function automatic logic funct3_legal(input logic [2:0] f3);
    logic legal;
    case (f3)
      BEQ, BNE, BLT, BGE, BLTU, BGEU: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3,
                                       input logic       zero,
                                       input logic       lt,
                                       input logic       ltu);
    logic cond;
    case (f3)
      BEQ:     cond = zero;
      BNE:     cond = ~zero;
      BLT:     cond = lt;
      BGE:     cond = ~lt;
      BLTU:    cond = ltu;
      BGEU:    cond = ~ltu;
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next state of a 2-bit saturating counter.
//  state : current counter value
//  taken : resolved direction (1 = count up, 0 = count down)
//  next  : updated value, held at SNT / ST at the limits
module sat_counter2
  import branch_pkg::*;
(
  input  bht_state_e state,
  input  logic       taken,
  output bht_state_e next
);

  // Saturating up/down step.
  always_comb begin
    next = state;
    case (state)
      SNT:     next = taken ? WNT : SNT;
      WNT:     next = taken ? WT  : SNT;
      WT:      next = taken ? ST  : WNT;
      ST:      next = taken ? ST  : WT;
      default: next = BHT_RESET_STATE;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with EX-stage branch resolution.
//  clk, rst         : clock, asynchronous active-high reset
//  if_pc            : fetch PC to look up
//  if_pred_taken    : prediction for if_pc (MSB of its BHT counter)
//  ex_valid         : EX holds a live instruction
//  ex_branch        : EX instruction is a conditional branch
//  ex_funct3        : branch type
//  ex_pc            : PC of the EX branch (selects the entry to train)
//  ex_pred_taken    : prediction carried down the pipe with this branch
//  zero/lt/ltu_flag : ALU comparison flags
//  take_branch      : resolved outcome
//  mispredict       : outcome differs from ex_pred_taken
//  stat_branches    : saturating count of resolved branches
//  stat_mispredicts : saturating count of mispredictions
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic             zero_flag,
  input  logic             lt_flag,
  input  logic             ltu_flag,
  output logic             take_branch,
  output logic             mispredict,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  // Flop array so the whole table clears asynchronously.
  bht_state_e       bht_r [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx_s;
  logic [IDX_W-1:0] ex_idx_s;
  bht_state_e       bht_cur_s;
  bht_state_e       bht_next_s;
  logic             act_s;
  logic             taken_s;
  logic [CNT_W-1:0] stat_branches_r;
  logic [CNT_W-1:0] stat_mispredicts_r;
  logic             unused_pc_bits_s;

  // Word-aligned PCs: bits [1:0] never contribute to the index.
  assign if_idx_s = if_pc[IDX_W+1:2];
  assign ex_idx_s = ex_pc[IDX_W+1:2];

  assign unused_pc_bits_s = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // Lookup reads the registered table directly: a same-cycle update is not bypassed.
  assign if_pred_taken = bht_r[if_idx_s][1];

  assign act_s   = ex_valid & ex_branch & funct3_legal(ex_funct3);
  assign taken_s = act_s & branch_cond(ex_funct3, zero_flag, lt_flag, ltu_flag);

  // Outputs are held low for the whole reset pulse, not just after the next edge.
  assign take_branch = ~rst & taken_s;
  assign mispredict  = ~rst & act_s & (taken_s ^ ex_pred_taken);

  assign bht_cur_s = bht_r[ex_idx_s];

  sat_counter2 u_sat_counter2 (
    .state (bht_cur_s),
    .taken (taken_s),
    .next  (bht_next_s)
  );

  // BHT training: only the entry addressed by ex_pc moves, and only on a live branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_r[i] <= BHT_RESET_STATE;
      end
    end else if (act_s) begin
      bht_r[ex_idx_s] <= bht_next_s;
    end
  end

  // Statistics counters, held at all-ones once full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_r    <= {CNT_W{1'b0}};
      stat_mispredicts_r <= {CNT_W{1'b0}};
    end else begin
      if (act_s && !(&stat_branches_r)) begin
        stat_branches_r <= stat_branches_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (act_s && (taken_s ^ ex_pred_taken) && !(&stat_mispredicts_r)) begin
        stat_mispredicts_r <= stat_mispredicts_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stat_branches    = stat_branches_r;
  assign stat_mispredicts = stat_mispredicts_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed cases with literal
// expectations, a counter-saturation run, then randomized traffic, all checked
// every cycle against a table-of-integers reference model.
module tb_branch_predict_unit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [XLEN-1:0]  if_pc = '0;
  logic             if_pred_taken;
  logic             ex_valid = 1'b0;
  logic             ex_branch = 1'b0;
  logic [2:0]       ex_funct3 = 3'd0;
  logic [XLEN-1:0]  ex_pc = '0;
  logic             ex_pred_taken = 1'b0;
  logic             zero_flag = 1'b0;
  logic             lt_flag = 1'b0;
  logic             ltu_flag = 1'b0;
  logic             take_branch;
  logic             mispredict;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_bht [ENTRIES];
  int m_br = 0;
  int m_mp = 0;

  branch_predict_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .zero_flag(zero_flag),
    .lt_flag(lt_flag), .ltu_flag(ltu_flag), .take_branch(take_branch),
    .mispredict(mispredict), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  // Model compare: at the falling edge inputs are stable; check, then apply the
  // effect of the coming rising edge to the model.
  always @(negedge clk) begin
    int  i_idx, e_idx;
    bit  legal, cond, act, tk, mp;
    i_idx = idx_of(if_pc);
    e_idx = idx_of(ex_pc);
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
      m_br = 0;
      m_mp = 0;
      act = 0;
      tk  = 0;
      mp  = 0;
    end else begin
      legal = 1;
      case (ex_funct3)
        3'd0: cond = zero_flag;
        3'd1: cond = !zero_flag;
        3'd4: cond = lt_flag;
        3'd5: cond = !lt_flag;
        3'd6: cond = ltu_flag;
        3'd7: cond = !ltu_flag;
        default: begin cond = 0; legal = 0; end
      endcase
      act = ex_valid && ex_branch && legal;
      tk  = act && cond;
      mp  = act && (tk != ex_pred_taken);
    end
    chk("model_pred", if_pred_taken, (m_bht[i_idx] >= 2) ? 1 : 0);
    chk("model_take", take_branch, tk);
    chk("model_misp", mispredict, mp);
    chk("model_stat_br", stat_branches, m_br);
    chk("model_stat_mp", stat_mispredicts, m_mp);
    if (act) begin
      if (tk) m_bht[e_idx] = (m_bht[e_idx] == 3) ? 3 : m_bht[e_idx] + 1;
      else    m_bht[e_idx] = (m_bht[e_idx] == 0) ? 0 : m_bht[e_idx] - 1;
      if (m_br < CNT_MAX) m_br++;
      if (mp && m_mp < CNT_MAX) m_mp++;
    end
  end

  // One cycle of stimulus, applied shortly after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic b, input logic [2:0] f3,
                     input logic [31:0] epc, input logic [31:0] ipc, input logic pred,
                     input logic z, input logic l, input logic lu);
    @(posedge clk);
    #2;
    rst = r; ex_valid = v; ex_branch = b; ex_funct3 = f3; ex_pc = epc;
    if_pc = ipc; ex_pred_taken = pred; zero_flag = z; lt_flag = l; ltu_flag = lu;
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, ipc, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // 1. reset
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(32'h0000_0104);
    chk("rst_pred", if_pred_taken, 1'b0);
    chk("rst_stat_br", stat_branches, 8'd0);
    chk("rst_stat_mp", stat_mispredicts, 8'd0);

    // 2. BEQ taken, predicted not taken
    cyc(1'b0, 1'b1, 1'b1, 3'b000, 32'h100, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("beq_take", take_branch, 1'b1);
    chk("beq_misp", mispredict, 1'b1);
    chk("beq_same_cycle_pred", if_pred_taken, 1'b0);
    idle(32'h100);
    chk("beq_next_pred", if_pred_taken, 1'b1);
    chk("beq_stat_mp", stat_mispredicts, 8'd1);

    // 3. BLTU not taken with pred=1, BGE taken
    cyc(1'b0, 1'b1, 1'b1, 3'b110, 32'h204, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("bltu_take", take_branch, 1'b0);
    chk("bltu_misp", mispredict, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 3'b101, 32'h208, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bge_take", take_branch, 1'b1);
    chk("bge_misp", mispredict, 1'b0);

    // 4. saturate entry of 0x48, then back off
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 1'b1, 1'b1, 3'b000, 32'h48, 32'h48, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 3'b001, 32'h48, 32'h48, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("st_pred", if_pred_taken, 1'b1);
    chk("bne_nt_misp", mispredict, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 3'b001, 32'h48, 32'h48, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wt_pred", if_pred_taken, 1'b1);
    idle(32'h48);
    chk("wnt_pred", if_pred_taken, 1'b0);

    // 5. illegal funct3 and bubble
    cyc(1'b0, 1'b1, 1'b1, 3'b010, 32'h48, 32'h48, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("ill_take", take_branch, 1'b0);
    chk("ill_misp", mispredict, 1'b0);
    chk("ill_stat_br", stat_branches, 8'd9);
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 32'h48, 32'h48, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bub_take", take_branch, 1'b0);
    chk("bub_misp", mispredict, 1'b0);
    idle(32'h48);
    chk("bub_stat_br", stat_branches, 8'd9);
    chk("bub_stat_mp", stat_mispredicts, 8'd4);
    chk("bub_pred", if_pred_taken, 1'b0);

    // 6. aliasing: train 0x140 (same entry as 0x100) while looking up 0x100
    cyc(1'b0, 1'b1, 1'b1, 3'b000, 32'h140, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alias_old_pred", if_pred_taken, 1'b1);
    idle(32'h100);
    chk("alias_new_pred", if_pred_taken, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 3'b111, 32'h4C, 32'h4C, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 3'b111, 32'h4C, 32'h4C, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(32'h4C);
    chk("pre_rst_pred", if_pred_taken, 1'b1);
    // mid-stream reset with a live taken branch pending
    cyc(1'b1, 1'b1, 1'b1, 3'b000, 32'h4C, 32'h4C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("midrst_pred", if_pred_taken, 1'b0);
    chk("midrst_take", take_branch, 1'b0);
    chk("midrst_misp", mispredict, 1'b0);
    chk("midrst_stat_br", stat_branches, 8'd0);
    idle(32'h4C);
    chk("postrst_pred", if_pred_taken, 1'b0);
    chk("postrst_stat_br", stat_branches, 8'd0);

    // Saturation of both statistics counters
    for (int k = 0; k < CNT_MAX + 20; k++)
      cyc(1'b0, 1'b1, 1'b1, 3'b000, $urandom, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(32'h0);
    chk("sat_stat_br", stat_branches, 8'hFF);
    chk("sat_stat_mp", stat_mispredicts, 8'hFF);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] epc;
      epc = $urandom;
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), epc,
          ($urandom_range(0, 3) == 0) ? epc : $urandom,
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(32'h0);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
